// File: rtl/feature_window_buffer.sv
// rtl/feature_window_buffer.sv - sliding window of per-frame feature tuples with hop-paced, signed-converted snapshots
module feature_window_buffer #(
    parameter int DATA_W      = 16,
    parameter int N_FEAT      = 2,
    parameter int N_FRAMES    = 13,
    parameter int HOP         = 1,
    parameter int SIGNED_MODE = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N_FEAT*DATA_W-1:0]           in_data,
    input  logic                               flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [DATA_W-1:0]           out_vector [N_FRAMES*N_FEAT],
    output logic [$clog2(N_FRAMES+1)-1:0]      fill_count,
    output logic                               overrun
);
    localparam int N_EL  = N_FRAMES * N_FEAT;
    localparam int CNT_W = $clog2(N_FRAMES + 1);
    localparam int HOP_W = (HOP > 1) ? $clog2(HOP) : 1;
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(N_FRAMES - 1);
    localparam logic [HOP_W-1:0] HOP_LAST  = HOP_W'(HOP - 1);

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [HOP_W-1:0]  r_hop_cnt;
    logic [DATA_W-1:0] r_window  [N_EL];
    logic [DATA_W-1:0] w_shifted [N_EL];
    logic              w_emit_due_next;
    logic              w_accept;
    logic              w_emit;
    logic              w_drop;

    function automatic logic [DATA_W-1:0] convert(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = v;
        if (SIGNED_MODE == 1) begin
            r[DATA_W-1] = ~v[DATA_W-1];
        end else if (SIGNED_MODE == 2 && v[DATA_W-1]) begin
            r = {1'b0, {(DATA_W-1){1'b1}}};
        end
        return r;
    endfunction

    // Only an accept that would load a snapshot can be stalled by a pending unconsumed one.
    always_comb begin
        w_emit_due_next = (r_state == S_FILL) ? (fill_count == FILL_LAST) : (r_hop_cnt == HOP_LAST);
        in_ready        = rst && !(out_valid && !out_ready && w_emit_due_next);
        w_accept        = in_valid && in_ready && !flush;
        w_emit          = w_accept && w_emit_due_next;
        w_drop          = in_valid && !in_ready && !flush;
    end

    always_comb begin
        for (int e = 0; e < N_EL; e++) begin
            if (e < N_FEAT) begin
                w_shifted[e] = in_data[e*DATA_W +: DATA_W];
            end else begin
                w_shifted[e] = r_window[e-N_FEAT];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_FILL;
        end else if (r_state == S_FILL && w_emit) begin
            w_state_next = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            fill_count <= '0;
            r_hop_cnt  <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            for (int e = 0; e < N_EL; e++) begin
                r_window[e]   <= '0;
                out_vector[e] <= '0;
            end
        end else begin
            if (w_drop) begin
                overrun <= 1'b1;
            end
            if (w_accept) begin
                for (int e = 0; e < N_EL; e++) begin
                    r_window[e] <= w_shifted[e];
                end
                if (r_state == S_FILL) begin
                    fill_count <= fill_count + CNT_W'(1);
                    r_hop_cnt  <= '0;
                end else begin
                    r_hop_cnt <= (r_hop_cnt == HOP_LAST) ? '0 : r_hop_cnt + HOP_W'(1);
                end
            end
            // A load in the same cycle as a transfer keeps out_valid high with fresh data.
            if (w_emit) begin
                out_valid <= 1'b1;
                for (int e = 0; e < N_EL; e++) begin
                    out_vector[e] <= $signed(convert(w_shifted[e]));
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/feature_window_buffer.md
Name: feature_window_buffer

Overview:
Parametrised successor to the per-frame statistics FIFO and the signed-conversion stage in the audio-processing top. It collects per-frame feature tuples (for example mean and std from the statistics stage) into a sliding window of N_FRAMES frames and applies a selectable signed conversion. It emits a registered feature vector to the classifier every HOP accepted frames, once the window is full. Adds valid/ready handshakes, hop control, flush, fill status and overrun detection.

Parameters:
DATA_W, 16, width of one feature value
N_FEAT, 2, features per frame (f0 = mean, f1 = std)
N_FRAMES, 13, frames held in window
HOP, 1, accepted frames between emitted vectors once full (1..N_FRAMES)
SIGNED_MODE, 0, 0 = bit reinterpret; 1 = offset-binary (invert MSB); 2 = saturating unsigned-to-signed

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_valid  in  1  input frame tuple valid
in_ready  out  1  buffer can accept tuple
in_data  in  N_FEAT*DATA_W  tuple; feature f at bits [f*DATA_W +: DATA_W]
flush  in  1  clear window and state
out_valid  out  1  out_vector holds an unconsumed snapshot
out_ready  in  1  consumer accepts snapshot
out_vector  out  signed DATA_W x (N_FRAMES*N_FEAT)  unpacked; index k*N_FEAT+f = feature f of frame age k (k=0 newest)
fill_count  out  $clog2(N_FRAMES+1)  frames held, saturates at N_FRAMES
overrun  out  1  sticky: in_valid seen while in_ready low

Behaviour:
- Reset (rst=0 at clk edge): window, out_vector, out_valid, fill_count, hop counter and overrun are 0; state is FILL. in_ready is 0 while rst=0.
- Accept: in_valid && in_ready. On accept, window[k] <= window[k-1] for k≥1 and window[0] <= in_data.
- States:
  - FILL: fill_count increments per accept. The accept making fill_count = N_FRAMES is emit_due. State goes to RUN and the hop counter is cleared.
  - RUN: the hop counter increments per accept (0..HOP-1). The accept with hop counter = HOP-1 is emit_due, and the counter wraps to 0. With HOP=1, every accept emits.
- Emission: on an emit_due accept, out_vector loads the converted post-shift window, including the frame just accepted. out_valid goes high the next cycle, so latency is 1 clock from the accept edge. out_vector is stable while out_valid=1.
- Output handshake: a transfer occurs when out_valid && out_ready. out_valid clears next cycle unless a new snapshot loads in the same cycle, in which case it stays 1 with the new data.
- in_ready = rst && !(out_valid && !out_ready && emit_due_next). emit_due_next is true if the next accept would be emit_due. Non-emitting accepts are never stalled by the output.
- Overrun: in_valid && !in_ready (with rst=1) sets overrun. The tuple is dropped and no state changes. Only reset or flush clears overrun.
- Flush (rst=1, flush=1):
  - Clears window, fill_count, hop counter, out_valid, out_vector and overrun; state goes to FILL.
  - Flush wins over a simultaneous in_valid (tuple discarded, no overrun) and over a simultaneous output transfer.
- Conversion (per element, at snapshot load, combinational inside the load path):
  - Mode 0: same bits.
  - Mode 1: MSB inverted.
  - Mode 2: values ≥ 2^(DATA_W-1) clamp to 2^(DATA_W-1)-1.
- The window is stored raw (unconverted); only out_vector is converted.
- Reset mid-operation: identical to power-on reset; any pending snapshot is lost.

Test Plan:
- Fill and emit: defaults, reset, then 13 consecutive accepts with mean=100+i, std=i (i=1..13) -> out_valid rises 1 cycle after the 13th accept; out_vector[0]=113, [1]=13, [24]=101, [25]=1; fill_count=13; no out_valid earlier.
- Backpressure with upstream ignoring in_ready: HOP=1, out_ready=0 after first emit, 14th tuple mean=200 -> in_ready=0, overrun=1, out_vector unchanged (out_vector[0]=113). Then out_ready=1 -> transfer, in_ready=1, next tuple accepted and emitted 1 cycle later.
- Hop: HOP=4, 13 fills then 8 more accepts -> snapshots after accepts 13, 17 and 21 only; the snapshot after accept 17 has out_vector[0]=mean of frame 17.
- Simultaneous consume/load: HOP=1, out_ready=1 held, in_valid=1 every cycle -> out_valid stays 1 continuously and out_vector[0] advances by one frame per cycle with no gaps.
- Conversion: SIGNED_MODE=1 with mean=16'h8000 -> element reads 0; SIGNED_MODE=2 with 16'hF000 -> 16'h7FFF; SIGNED_MODE=0 with 16'hF000 -> -4096.
- Flush and reset: flush asserted with in_valid=1 while out_valid=1 -> next cycle out_valid=0, fill_count=0, overrun=0, all out_vector elements 0; a following 12 accepts produce no emit. rst=0 mid-run gives the same cleared state and in_ready=0 during reset.
